// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES round scheduler: controller state encoding,
// round count and key/schedule widths.
// No ports (package).
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int NUM_ROUNDS = 10;
    localparam int KEY_W      = 128;
    localparam int SCHED_W    = 1408;   // (NUM_ROUNDS + 1) round keys
    localparam int RND_W      = 4;

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_KLOAD = 3'd1,
        ST_KEXP  = 3'd2,
        ST_READY = 3'd3,
        ST_ROUND = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/aes_round_sched_if.sv
// -----------------------------------------------------------------------------
// aes_round_sched_if
// Host-side handshakes of the AES round scheduler.
//   key_req / key_in / key_ack : key-load request, key, one-cycle acknowledge
//   in_valid / in_ready        : block-request handshake
//   out_valid / out_ready      : result handshake
// Modports: master = host, slave = scheduler.
// -----------------------------------------------------------------------------
interface aes_round_sched_if;
    import aes_pkg::*;

    logic             key_req;
    logic [KEY_W-1:0] key_in;
    logic             key_ack;
    logic             in_valid;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output key_req, key_in, in_valid, out_ready,
        input  key_ack, in_ready, out_valid
    );

    modport slave (
        input  key_req, key_in, in_valid, out_ready,
        output key_ack, in_ready, out_valid
    );

endinterface

// File: rtl/aes_rk_select.sv
// -----------------------------------------------------------------------------
// aes_rk_select
// 11-way round-key multiplexer. Round key r sits at
// i_sched[SCHED_W-1-KEY_W*r -: KEY_W]. Output is zero when i_en is low.
// Ports:
//   i_sched : full key schedule (11 x 128 bits)
//   i_round : round index 0..10
//   i_en    : select enable
//   o_key   : selected round key
// -----------------------------------------------------------------------------
module aes_rk_select
    import aes_pkg::*;
(
    input  logic [SCHED_W-1:0] i_sched,
    input  logic [RND_W-1:0]   i_round,
    input  logic               i_en,
    output logic [KEY_W-1:0]   o_key
);

    always_comb begin
        o_key = '0;
        for (int r = 0; r <= NUM_ROUNDS; r++) begin
            if (i_en && (i_round == RND_W'(r))) begin
                o_key = i_sched[SCHED_W-1-KEY_W*r -: KEY_W];
            end
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// -----------------------------------------------------------------------------
// aes_round_sched
// Control FSM sequencing an AES-128 key load through an external keyexpansion
// block and then stepping a round datapath through rounds 0..10 per block.
// Optional macro: AES_SCHED_TIMEOUT_EN adds a KEXP watchdog (TIMEOUT_CYCLES)
// and the sticky kx_timeout output.
// Ports:
//   clk, rst             : clock, asynchronous active-low reset
//   host                 : key / block / result handshakes (slave modport)
//   kx_key, kx_start     : registered key and start pulse to keyexpansion
//   kx_finish, kx_out    : keyexpansion done and its 11 round keys
//   rd_load/step/last    : round-datapath controls
//   rd_key, rd_round     : current round key and index (0 when idle)
//   busy                 : high outside IDLE and READY
//   kx_timeout           : sticky abort flag (AES_SCHED_TIMEOUT_EN only)
// -----------------------------------------------------------------------------
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
)
(
    input  logic               clk,
    input  logic               rst,
    aes_round_sched_if.slave   host,
    output logic [KEY_W-1:0]   kx_key,
    output logic               kx_start,
    input  logic               kx_finish,
    input  logic [SCHED_W-1:0] kx_out,
    output logic               rd_load,
    output logic               rd_step,
    output logic               rd_last,
    output logic [KEY_W-1:0]   rd_key,
    output logic [RND_W-1:0]   rd_round,
    output logic               busy
`ifdef AES_SCHED_TIMEOUT_EN
    ,
    output logic               kx_timeout
`endif
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    state_t             r_state;
    logic [KEY_W-1:0]   r_kx_key;
    logic               r_kx_start;
    logic               r_key_ack;
    logic               r_rd_load;
    logic               r_rd_step;
    logic               r_rd_last;
    logic [RND_W-1:0]   r_rd_round;
    logic               r_out_valid;

    logic               w_in_ready;
    logic               w_key_accept;
    logic               w_block_accept;

`ifdef AES_SCHED_TIMEOUT_EN
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_kx_timeout;
    assign kx_timeout = r_kx_timeout;
`else
    // Keeps TIMEOUT_CYCLES referenced when the watchdog is compiled out.
    logic [TMO_W-1:0]   w_unused_tmo;
    assign w_unused_tmo = '0;
`endif

    // key_req is still high during the key_ack cycle (the requester drops it
    // only after seeing the ack), so READY must not re-accept it then.
    assign w_key_accept   = host.key_req &&
                            ((r_state == ST_IDLE) ||
                             ((r_state == ST_READY) && !r_key_ack));
    assign w_in_ready     = (r_state == ST_READY) && !host.key_req;
    assign w_block_accept = host.in_valid && w_in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_kx_key     <= '0;
            r_kx_start   <= 1'b0;
            r_key_ack    <= 1'b0;
            r_rd_load    <= 1'b0;
            r_rd_step    <= 1'b0;
            r_rd_last    <= 1'b0;
            r_rd_round   <= '0;
            r_out_valid  <= 1'b0;
`ifdef AES_SCHED_TIMEOUT_EN
            r_tmo_cnt    <= '0;
            r_kx_timeout <= 1'b0;
`endif
        end else begin
            r_kx_start <= 1'b0;
            r_key_ack  <= 1'b0;
            if (w_key_accept) begin
                r_kx_key   <= host.key_in;
                r_kx_start <= 1'b1;
                r_state    <= ST_KLOAD;
`ifdef AES_SCHED_TIMEOUT_EN
                r_kx_timeout <= 1'b0;
`endif
            end else begin
                case (r_state)
                    ST_KLOAD: begin
                        r_state <= ST_KEXP;
`ifdef AES_SCHED_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                    ST_KEXP: begin
                        if (kx_finish) begin
                            r_key_ack <= 1'b1;
                            r_state   <= ST_READY;
                        end
`ifdef AES_SCHED_TIMEOUT_EN
                        else if (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                            r_kx_timeout <= 1'b1;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_tmo_cnt <= r_tmo_cnt + 1'b1;
                        end
`endif
                    end
                    ST_READY: begin
                        if (w_block_accept) begin
                            r_rd_load  <= 1'b1;
                            r_rd_round <= '0;
                            r_state    <= ST_ROUND;
                        end
                    end
                    ST_ROUND: begin
                        if (r_rd_round == LAST_RND) begin
                            r_rd_load   <= 1'b0;
                            r_rd_step   <= 1'b0;
                            r_rd_last   <= 1'b0;
                            r_rd_round  <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_rd_load  <= 1'b0;
                            r_rd_step  <= 1'b1;
                            r_rd_round <= r_rd_round + 1'b1;
                            r_rd_last  <= (r_rd_round == LAST_RND - 1'b1);
                        end
                    end
                    ST_DONE: begin
                        if (host.out_ready) begin
                            r_out_valid <= 1'b0;
                            r_state     <= ST_READY;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    // kx_out is held stable by keyexpansion, so the mux reads it directly.
    aes_rk_select u_rk_select (
        .i_sched (kx_out),
        .i_round (r_rd_round),
        .i_en    (r_rd_load | r_rd_step),
        .o_key   (rd_key)
    );

    assign kx_key         = r_kx_key;
    assign kx_start       = r_kx_start;
    assign host.key_ack   = r_key_ack;
    assign host.in_ready  = w_in_ready;
    assign host.out_valid = r_out_valid;
    assign rd_load        = r_rd_load;
    assign rd_step        = r_rd_step;
    assign rd_last        = r_rd_last;
    assign rd_round       = r_rd_round;
    assign busy           = (r_state != ST_IDLE) && (r_state != ST_READY);

endmodule
